// File: rtl/booth_divider_if.sv
// Start/done handshake bundle for booth_divider: operands in, results and flags out.
// The master modport drives requests; the slave modport is the divider side.
interface booth_divider_if #(
    parameter int REG_WIDTH = 4,
    parameter int OUT_WIDTH = 8
);
    logic                 start;
    logic [OUT_WIDTH-1:0] dividend;
    logic [REG_WIDTH-1:0] divisor;
    logic                 busy;
    logic                 done;
    logic [OUT_WIDTH-1:0] quotient;
    logic [REG_WIDTH-1:0] remainder;
    logic                 dz;
    logic                 ovf;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dz, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dz, ovf
    );
endinterface

// File: rtl/booth_divider.sv
// Sequential signed restoring divider (truncating), one quotient bit per cycle.
// Define BOOTH_DIV_RADIX4_EN to retire two quotient bits per cycle instead.
module booth_divider #(
    parameter int REG_WIDTH = 4,
    parameter int OUT_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    booth_divider_if.slave  bus
);

`ifdef BOOTH_DIV_RADIX4_EN
    localparam int STEPS = 2;
`else
    localparam int STEPS = 1;
`endif

    localparam int PR_W  = REG_WIDTH + 1;
    localparam int CNT_W = $clog2(OUT_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OUT_WIDTH / STEPS);
    localparam logic [OUT_WIDTH-1:0] Q_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [OUT_WIDTH-1:0] dd_reg, dd_next;       // dividend magnitude, becomes Qmag
    logic [REG_WIDTH-1:0] dvs_reg, dvs_next;
    logic [PR_W-1:0]      pr_reg, pr_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic                 sign_q_reg, sign_q_next;
    logic                 sign_r_reg, sign_r_next;
    logic [OUT_WIDTH-1:0] quotient_reg, quotient_next;
    logic [REG_WIDTH-1:0] remainder_reg, remainder_next;
    logic                 dz_reg, dz_next;
    logic                 ovf_reg, ovf_next;
    logic                 done_reg, done_next;

    // Iteration datapath: STEPS chained shift/trial-subtract/restore stages.
    logic [OUT_WIDTH-1:0] iter_dd;
    logic [PR_W-1:0]      iter_pr;
    logic [PR_W:0]        shifted;
    logic [PR_W+1:0]      trial;

    always_comb begin
        iter_dd = dd_reg;
        iter_pr = pr_reg;
        shifted = '0;
        trial   = '0;
        for (int i = 0; i < STEPS; i++) begin
            shifted = {iter_pr, iter_dd[OUT_WIDTH-1]};
            trial   = {1'b0, shifted} - {{(PR_W-REG_WIDTH+2){1'b0}}, dvs_reg};
            if (trial[PR_W+1]) begin
                iter_pr = PR_W'(shifted);
                iter_dd = {iter_dd[OUT_WIDTH-2:0], 1'b0};
            end else begin
                iter_pr = PR_W'(trial);
                iter_dd = {iter_dd[OUT_WIDTH-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            dd_reg        <= '0;
            dvs_reg       <= '0;
            pr_reg        <= '0;
            cnt_reg       <= '0;
            sign_q_reg    <= 1'b0;
            sign_r_reg    <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dz_reg        <= 1'b0;
            ovf_reg       <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            dd_reg        <= dd_next;
            dvs_reg       <= dvs_next;
            pr_reg        <= pr_next;
            cnt_reg       <= cnt_next;
            sign_q_reg    <= sign_q_next;
            sign_r_reg    <= sign_r_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dz_reg        <= dz_next;
            ovf_reg       <= ovf_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        dd_next        = dd_reg;
        dvs_next       = dvs_reg;
        pr_next        = pr_reg;
        cnt_next       = cnt_reg;
        sign_q_next    = sign_q_reg;
        sign_r_next    = sign_r_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dz_next        = dz_reg;
        ovf_next       = ovf_reg;
        done_next      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    dd_next     = bus.dividend[OUT_WIDTH-1] ? -bus.dividend : bus.dividend;
                    dvs_next    = bus.divisor[REG_WIDTH-1]  ? -bus.divisor  : bus.divisor;
                    sign_q_next = bus.dividend[OUT_WIDTH-1] ^ bus.divisor[REG_WIDTH-1];
                    sign_r_next = bus.dividend[OUT_WIDTH-1];
                    pr_next     = '0;
                    cnt_next    = CNT_LOAD;
                    state_next  = (bus.divisor == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                dd_next  = iter_dd;
                pr_next  = iter_pr;
                cnt_next = cnt_reg - 1'b1;
                // The last iteration happens on the edge that brings the counter to zero.
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = S_SIGN;
                end
            end
            S_SIGN: begin
                // Only -2^(N-1) / -1 yields a positive magnitude of 2^(N-1).
                ovf_next       = (dd_reg == Q_MIN) && !sign_q_reg;
                quotient_next  = sign_q_reg ? -dd_reg : dd_reg;
                if ((dd_reg == Q_MIN) && !sign_q_reg) begin
                    remainder_next = '0;
                end else begin
                    remainder_next = sign_r_reg ? REG_WIDTH'(-pr_reg) : REG_WIDTH'(pr_reg);
                end
                dz_next    = 1'b0;
                done_next  = 1'b1;
                state_next = S_IDLE;
            end
            S_DONE: begin
                quotient_next  = '1;
                remainder_next = '0;
                dz_next        = 1'b1;
                ovf_next       = 1'b0;
                done_next      = 1'b1;
                state_next     = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.busy      = (state_reg != S_IDLE);
    assign bus.done      = done_reg;
    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
    assign bus.dz        = dz_reg;
    assign bus.ovf       = ovf_reg;

endmodule
